// File: rtl/uart_tx_word_arbiter_pkg.sv
// Shared types and helpers for the UART word arbiter.
package uart_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } arb_state_t;

  // Number of byte-sized parts in one requester word.
  function automatic int unsigned parts(input int unsigned ws, input int unsigned wp);
    return ws / wp;
  endfunction

endpackage

// File: rtl/uart_tx_word_arbiter_if.sv
// Requester bus and UART byte channel seen by the word arbiter.
interface uart_tx_word_arbiter_if #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned WORD_PART = 8
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ*WORD_SIZE-1:0] req_data;
  logic [N_REQ-1:0]           req_ready;
  logic [WORD_PART-1:0]       tx_data;
  logic                       tx_valid;
  logic                       tx_ready;
  logic [IDX_W-1:0]           grant_id;
  logic                       busy;

  // Arbiter side.
  modport master (
    input  req_valid, req_data, tx_ready,
    output req_ready, tx_data, tx_valid, grant_id, busy
  );

  // Producer / UART side.
  modport slave (
    output req_valid, req_data, tx_ready,
    input  req_ready, tx_data, tx_valid, grant_id, busy
  );

endinterface

// File: rtl/uart_tx_word_arbiter_rr_arbiter.sv
// Round-robin picker: first active request at or above ptr, wrapping mod N_REQ.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic                     any
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  int unsigned cand;
  logic        found;

  // Rotating priority search starting at the pointer.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    any       = |req;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = (32'(ptr) + k) % N_REQ;
      if (!found && req[IDX_W'(cand)]) begin
        found     = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
    if (found) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_word_arbiter.sv
// Shares one UART byte channel between N_REQ word producers: round-robin
// grant, capture the word, send it part by part, then re-arbitrate.
module uart_tx_word_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned WORD_PART = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic                    clock,
  input logic                    reset,
  uart_tx_word_arbiter_if.master bus
);

  localparam int unsigned PARTS = parts(WORD_SIZE, WORD_PART);
  localparam int unsigned CNT_W = (PARTS > 1) ? $clog2(PARTS) : 1;
  localparam int unsigned IDX_W = $clog2(N_REQ);

  arb_state_t           state_q, state_nxt;
  logic [WORD_SIZE-1:0] shift_q, shift_nxt, shifted, word_sel;
  logic [CNT_W-1:0]     cnt_q, cnt_nxt;
  logic [IDX_W-1:0]     ptr_q, ptr_nxt;
  logic [IDX_W-1:0]     grant_q, grant_nxt;
  logic                 busy_q, busy_nxt;
  logic                 tx_valid_q, tx_valid_nxt;
  logic [WORD_PART-1:0] tx_data_q, tx_data_nxt;
  logic [N_REQ-1:0]     req_ready_c;

  logic [N_REQ-1:0]     arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req       (bus.req_valid),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  // Part that goes out first from a (possibly already shifted) word.
  function automatic logic [WORD_PART-1:0] head_part(input logic [WORD_SIZE-1:0] w);
    if (MSB_FIRST) return w[WORD_SIZE-1 -: WORD_PART];
    else           return w[WORD_PART-1:0];
  endfunction

  // Word offered by the current arbitration winner.
  assign word_sel = bus.req_data[32'(arb_idx) * WORD_SIZE +: WORD_SIZE];

  // Next state and datapath: accept in IDLE, shift out one part per transfer in SEND.
  always_comb begin
    state_nxt    = state_q;
    shift_nxt    = shift_q;
    cnt_nxt      = cnt_q;
    ptr_nxt      = ptr_q;
    grant_nxt    = grant_q;
    busy_nxt     = busy_q;
    tx_valid_nxt = tx_valid_q;
    tx_data_nxt  = tx_data_q;
    req_ready_c  = '0;
    shifted      = MSB_FIRST ? (shift_q << WORD_PART) : (shift_q >> WORD_PART);
    case (state_q)
      IDLE: begin
        req_ready_c = arb_grant;
        if (arb_any) begin
          shift_nxt    = word_sel;
          cnt_nxt      = '0;
          grant_nxt    = arb_idx;
          ptr_nxt      = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
          busy_nxt     = 1'b1;
          tx_valid_nxt = 1'b1;
          tx_data_nxt  = head_part(word_sel);
          state_nxt    = SEND;
        end
      end
      SEND: begin
        if (tx_valid_q && bus.tx_ready) begin
          if (cnt_q == CNT_W'(PARTS - 1)) begin
            shift_nxt    = '0;
            cnt_nxt      = '0;
            busy_nxt     = 1'b0;
            tx_valid_nxt = 1'b0;
            tx_data_nxt  = '0;
            state_nxt    = IDLE;
          end else begin
            shift_nxt   = shifted;
            cnt_nxt     = cnt_q + CNT_W'(1);
            tx_data_nxt = head_part(shifted);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      ptr_q      <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      shift_q    <= shift_nxt;
      cnt_q      <= cnt_nxt;
      ptr_q      <= ptr_nxt;
      grant_q    <= grant_nxt;
      busy_q     <= busy_nxt;
      tx_valid_q <= tx_valid_nxt;
      tx_data_q  <= tx_data_nxt;
    end
  end

  // Acceptance is suppressed while reset is held.
  assign bus.req_ready = reset ? '0 : req_ready_c;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_word_arbiter.sv
// Self-checking bench for uart_tx_word_arbiter: vector table with a byte
// scoreboard, plus hand sequences for LSB-first order and reset mid-word.
module tb_uart_tx_word_arbiter;

  localparam int unsigned N_REQ     = 4;
  localparam int unsigned WORD_SIZE = 32;
  localparam int unsigned WORD_PART = 8;
  localparam int unsigned PARTS     = WORD_SIZE / WORD_PART;
  localparam int unsigned MAX_G     = 8;
  localparam int unsigned N_VEC     = 5;

  typedef struct {
    int unsigned cnt [N_REQ];    // words each requester offers
    logic [31:0] base;           // seed for word contents
    int unsigned ready_mode;     // 0 always, 1 one-in-three, 2 random
    int unsigned n_grants;       // expected number of grants
    int unsigned grants [MAX_G]; // expected grant order
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  uart_tx_word_arbiter_if #(.N_REQ(N_REQ), .WORD_SIZE(WORD_SIZE), .WORD_PART(WORD_PART)) bus ();
  uart_tx_word_arbiter_if #(.N_REQ(N_REQ), .WORD_SIZE(WORD_SIZE), .WORD_PART(WORD_PART)) bus_lsb ();

  uart_tx_word_arbiter #(.N_REQ(N_REQ), .WORD_SIZE(WORD_SIZE), .WORD_PART(WORD_PART), .MSB_FIRST(1'b1))
    dut (.clock(clock), .reset(reset), .bus(bus));

  uart_tx_word_arbiter #(.N_REQ(N_REQ), .WORD_SIZE(WORD_SIZE), .WORD_PART(WORD_PART), .MSB_FIRST(1'b0))
    dut_lsb (.clock(clock), .reset(reset), .bus(bus_lsb));

  int unsigned checks = 0;
  int unsigned errors = 0;
  vec_t        vecs [N_VEC];
  int unsigned sent [N_REQ];
  logic [7:0]  exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] base, input int unsigned r,
                                          input int unsigned k);
    return base + 32'(r) * 32'h01030507 + 32'(k) * 32'h10204081;
  endfunction

  task automatic idle_inputs();
    bus.req_valid     = '0;
    bus.req_data      = '0;
    bus.tx_ready      = 1'b0;
    bus_lsb.req_valid = '0;
    bus_lsb.req_data  = '0;
    bus_lsb.tx_ready  = 1'b0;
  endtask

  // Hold reset for a cycle with requests pending; outputs must read as reset values.
  task automatic apply_reset();
    idle_inputs();
    bus.req_valid = '1;
    reset = 1'b1;
    @(posedge clock); #1;
    check("rst_tx_valid", 32'(bus.tx_valid), 0);
    check("rst_tx_data", 32'(bus.tx_data), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_grant_id", 32'(bus.grant_id), 0);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_lsb_tx_valid", 32'(bus_lsb.tx_valid), 0);
    bus.req_valid = '0;
    reset = 1'b0;
  endtask

  task automatic drive_inputs(input int unsigned v, input int unsigned cyc);
    for (int unsigned r = 0; r < N_REQ; r++) begin
      bus.req_valid[r] = (sent[r] < vecs[v].cnt[r]);
      bus.req_data[r*WORD_SIZE +: WORD_SIZE] = bus.req_valid[r] ?
                                               word_of(vecs[v].base, r, sent[r]) : '0;
    end
    case (vecs[v].ready_mode)
      0:       bus.tx_ready = 1'b1;
      1:       bus.tx_ready = ((cyc % 3) == 0);
      default: bus.tx_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Run one table vector: producers model, byte scoreboard and handshake monitor.
  task automatic run_vec(input int unsigned v);
    int unsigned gi, cyc, idx, last_acc;
    bit          have_last, prev_stall, chk_gid, done;
    logic [7:0]  prev_data;
    logic [N_REQ-1:0] acc;
    logic [31:0] w;
    int unsigned exp_gid;

    apply_reset();
    for (int unsigned r = 0; r < N_REQ; r++) sent[r] = 0;
    exp_q.delete();
    gi = 0; cyc = 0; last_acc = 0; have_last = 0; prev_stall = 0; chk_gid = 0; done = 0;
    prev_data = '0; exp_gid = 0; idx = 0;
    drive_inputs(v, cyc);

    while (cyc < 200 && !done) begin
      @(negedge clock);
      if (chk_gid) begin
        check("grant_id", 32'(bus.grant_id), exp_gid);
        check("busy_in_send", 32'(bus.busy), 1);
        check("valid_after_accept", 32'(bus.tx_valid), 1);
        chk_gid = 0;
      end
      if (prev_stall) begin
        check("hold_valid", 32'(bus.tx_valid), 1);
        check("hold_data", 32'(bus.tx_data), 32'(prev_data));
      end
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_data  = bus.tx_data;

      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) check("extra_part", 32'(bus.tx_data), 32'hFFFF_FFFF);
        else                   check("part", 32'(bus.tx_data), 32'(exp_q.pop_front()));
      end

      acc = bus.req_valid & bus.req_ready;
      if (acc != '0) begin
        check("ready_onehot", 32'($countones(bus.req_ready)), 1);
        for (int unsigned r = 0; r < N_REQ; r++) if (acc[r]) idx = r;
        if (gi < vecs[v].n_grants) check("grant_order", idx, vecs[v].grants[gi]);
        else                       check("extra_grant", idx, 32'hFFFF_FFFF);
        if (vecs[v].ready_mode == 0 && have_last) check("grant_gap", cyc - last_acc, PARTS + 1);
        have_last = 1;
        last_acc  = cyc;
        gi++;
        w = word_of(vecs[v].base, idx, sent[idx]);
        for (int unsigned p = 0; p < PARTS; p++) exp_q.push_back(w[WORD_SIZE-1-p*WORD_PART -: 8]);
        sent[idx]++;
        exp_gid = idx;
        chk_gid = 1;
      end

      done = (gi >= vecs[v].n_grants) && (exp_q.size() == 0) && !bus.busy && !chk_gid;
      @(posedge clock); #1;
      cyc++;
      drive_inputs(v, cyc);
    end

    check("vec_done", 32'(done), 1);
    check("vec_grants", gi, vecs[v].n_grants);
    @(negedge clock);
    check("end_busy", 32'(bus.busy), 0);
    check("end_tx_valid", 32'(bus.tx_valid), 0);
  endtask

  // LSB-first instance: DEADBEEF goes out as EF,BE,AD,DE; requester drops valid after acceptance.
  task automatic lsb_seq();
    logic [7:0]  got [PARTS];
    logic [7:0]  exp_lsb [PARTS];
    int unsigned got_n;
    bit          acc_seen;
    exp_lsb = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    apply_reset();
    got_n = 0; acc_seen = 0;
    for (int unsigned i = 0; i < PARTS; i++) got[i] = '0;
    bus_lsb.req_valid = 4'b0001;
    bus_lsb.req_data[WORD_SIZE-1:0] = 32'hDEADBEEF;
    bus_lsb.tx_ready = 1'b1;
    for (int c = 0; c < 20 && got_n < PARTS; c++) begin
      @(negedge clock);
      if (bus_lsb.tx_valid && bus_lsb.tx_ready) begin
        got[got_n] = bus_lsb.tx_data;
        got_n++;
      end
      if (bus_lsb.req_valid[0] && bus_lsb.req_ready[0]) acc_seen = 1;
      @(posedge clock); #1;
      if (acc_seen) begin
        bus_lsb.req_valid = '0;
        bus_lsb.req_data  = '1;
      end
    end
    check("lsb_count", got_n, PARTS);
    for (int unsigned i = 0; i < PARTS; i++) check("lsb_part", 32'(got[i]), 32'(exp_lsb[i]));
    @(negedge clock);
    check("lsb_busy_after", 32'(bus_lsb.busy), 0);
    bus_lsb.tx_ready = 1'b0;
  endtask

  // Reset after the 2nd part of 11223344, then the word must restart at 11.
  task automatic reset_mid_seq();
    logic [7:0]  got [PARTS];
    logic [7:0]  exp_msb [PARTS];
    int unsigned got_n;
    exp_msb = '{8'h11, 8'h22, 8'h33, 8'h44};
    apply_reset();
    got_n = 0;
    bus.req_valid = 4'b0001;
    bus.req_data[WORD_SIZE-1:0] = 32'h11223344;
    bus.tx_ready = 1'b1;
    for (int c = 0; c < 20 && got_n < 2; c++) begin
      @(negedge clock);
      if (bus.req_valid[0] && bus.req_ready[0]) begin
        @(posedge clock); #1;
        bus.req_valid = '0;
      end else begin
        if (bus.tx_valid && bus.tx_ready) got_n++;
        @(posedge clock); #1;
      end
    end
    check("pre_reset_parts", got_n, 2);
    check("pre_reset_data", 32'(bus.tx_data), 32'h33);
    reset = 1'b1;
    #1;
    check("mid_rst_tx_valid", 32'(bus.tx_valid), 0);
    check("mid_rst_tx_data", 32'(bus.tx_data), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    got_n = 0;
    for (int unsigned i = 0; i < PARTS; i++) got[i] = '0;
    bus.req_valid = 4'b0001;
    for (int c = 0; c < 20 && got_n < PARTS; c++) begin
      @(negedge clock);
      if (bus.tx_valid && bus.tx_ready) begin
        got[got_n] = bus.tx_data;
        got_n++;
      end
      if (bus.req_valid[0] && bus.req_ready[0]) begin
        @(posedge clock); #1;
        bus.req_valid = '0;
      end else begin
        @(posedge clock); #1;
      end
    end
    check("restart_count", got_n, PARTS);
    for (int unsigned i = 0; i < PARTS; i++) check("restart_part", 32'(got[i]), 32'(exp_msb[i]));
  endtask

  initial begin
    vecs[0].cnt = '{1, 0, 0, 0}; vecs[0].base = 32'hDEADBEEF; vecs[0].ready_mode = 0;
    vecs[0].n_grants = 1; vecs[0].grants = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1].cnt = '{2, 1, 1, 1}; vecs[1].base = 32'h01234567; vecs[1].ready_mode = 0;
    vecs[1].n_grants = 5; vecs[1].grants = '{0, 1, 2, 3, 0, 0, 0, 0};
    vecs[2].cnt = '{0, 0, 3, 0}; vecs[2].base = 32'hCAFEF00D; vecs[2].ready_mode = 0;
    vecs[2].n_grants = 3; vecs[2].grants = '{2, 2, 2, 0, 0, 0, 0, 0};
    vecs[3].cnt = '{1, 0, 1, 0}; vecs[3].base = 32'hA5A55A5A; vecs[3].ready_mode = 1;
    vecs[3].n_grants = 2; vecs[3].grants = '{0, 2, 0, 0, 0, 0, 0, 0};
    vecs[4].cnt = '{0, 2, 0, 1}; vecs[4].base = 32'h0F1E2D3C; vecs[4].ready_mode = 2;
    vecs[4].n_grants = 3; vecs[4].grants = '{1, 3, 1, 0, 0, 0, 0, 0};

    reset = 1'b1;
    idle_inputs();
    for (int unsigned v = 0; v < N_VEC; v++) run_vec(v);
    lsb_seq();
    reset_mid_seq();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
